// File: rtl/count_ctrl_pkg.sv
// Shared types and defaults for the run/pause/clear counter controller.
// State encoding, default limits and the load-value clamp live here.
package count_ctrl_pkg;

    localparam int DEF_CNT_W           = 7;
    localparam int DEF_MAX_COUNT       = 99;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Up-count always starts from zero; down-count starts from the preset,
    // clamped so an out-of-range switch setting can never exceed the limit.
    function automatic int unsigned load_value(input logic up,
                                               input int unsigned preset,
                                               input int unsigned max_count);
        if (up)
            return 0;
        return (preset > max_count) ? max_count : preset;
    endfunction

endpackage

// File: rtl/count_ctrl_fsm_if.sv
// Board-side signal bundle of the counter controller: strobe, keys, switches
// and the count/state outputs that feed the display decode.
interface count_ctrl_fsm_if #(
    parameter int CNT_W = count_ctrl_pkg::DEF_CNT_W
);
    logic             tick;
    logic             key_start_n;
    logic             key_clr_n;
    logic             up_down;
    logic             wrap_en;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic [1:0]       state;
    logic             running;
    logic             done;

    modport master (
        output tick, key_start_n, key_clr_n, up_down, wrap_en, preset,
        input  count, state, running, done
    );

    modport slave (
        input  tick, key_start_n, key_clr_n, up_down, wrap_en, preset,
        output count, state, running, done
    );
endinterface

// File: rtl/key_debounce.sv
// Synchronises and debounces one raw active-low pushbutton and emits a
// one-cycle press pulse on the accepted high-to-low transition.
module key_debounce
    import count_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n_a,
    input  logic key_n,
    output logic press
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [1:0]    vld;
    logic          level;
    logic          level_d;
    logic          armed;
    logic [CW-1:0] cnt;

    // A key held through reset must be seen released before it may fire, so
    // presses stay disarmed until a valid synchronised high is observed.
    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            // NOTE: synchroniser and level reset to 1 (released) so leaving reset never looks like a press.
            sync    <= 2'b11;
            vld     <= 2'b00;
            level   <= 1'b1;
            level_d <= 1'b1;
            armed   <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every flop samples pre-edge values.
            sync    <= {sync[0], key_n};
            vld     <= {vld[0], 1'b1};
            level_d <= level;
            press   <= level_d & ~level & armed;
            if (vld[1] && sync[1])
                armed <= 1'b1;

            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/count_ctrl_fsm.sv
// Run/pause/clear controller owning the two-digit count register, direction,
// wrap/saturate policy and the terminal-count pulse.
module count_ctrl_fsm
    import count_ctrl_pkg::*;
#(
    parameter int CNT_W           = DEF_CNT_W,
    parameter int MAX_COUNT       = DEF_MAX_COUNT,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n_a,
    count_ctrl_fsm_if.slave bus
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

    logic             start_ev;
    logic             clr_ev;
    state_e           state_q;
    logic [CNT_W-1:0] count_q;
    logic             done_q;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] step_val;
    logic             hit_end;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_key (
        .clk     (clk),
        .rst_n_a (rst_n_a),
        .key_n   (bus.key_start_n),
        .press   (start_ev)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_key (
        .clk     (clk),
        .rst_n_a (rst_n_a),
        .key_n   (bus.key_clr_n),
        .press   (clr_ev)
    );

    // Next count for a tick; hit_end flags a limit reached with wrap disabled.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        step_val = count_q;
        hit_end  = 1'b0;
        load_val = CNT_W'(load_value(bus.up_down, 32'(bus.preset), 32'(MAX_COUNT)));
        if (bus.up_down) begin
            if (count_q >= MAX_C) begin
                if (bus.wrap_en) step_val = '0;
                else             hit_end  = 1'b1;
            end else begin
                step_val = count_q + CNT_W'(1);
            end
        end else begin
            if (count_q == '0) begin
                if (bus.wrap_en) step_val = MAX_C;
                else             hit_end  = 1'b1;
            end else begin
                step_val = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clr_ev)
                        count_q <= load_val;
                    else if (start_ev)
                        state_q <= ST_RUN;
                end
                ST_RUN: begin
                    // Clear beats start and tick; start with a tick keeps the step.
                    if (clr_ev) begin
                        state_q <= ST_IDLE;
                        count_q <= load_val;
                    end else begin
                        if (bus.tick)
                            count_q <= step_val;
                        if (start_ev) begin
                            state_q <= ST_PAUSE;
                        end else if (bus.tick && hit_end) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (clr_ev) begin
                        state_q <= ST_IDLE;
                        count_q <= load_val;
                    end else if (start_ev) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (clr_ev || start_ev) begin
                        state_q <= ST_IDLE;
                        count_q <= load_val;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.count   = count_q;
    assign bus.state   = state_q;
    assign bus.running = (state_q == ST_RUN);
    assign bus.done    = done_q;

endmodule
